writeback_arbiter: RTL and testbench

//  Sits directly upstream of the register-file write port and drives its wen/wsel/wdata.

---
 rtl/writeback_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write-port arbiter for ALU and load results
//
// Purpose:
//   Drives the register-file write port (wen/wsel/wdata) from two sources.
//   ALU results arrive one per cycle and are never back-pressured.
//   Load results use a valid/ready handshake and wait in a small FIFO.
//   o_busy_mask reports which registers still have a queued load write.
//   The issue stage uses it for hazard checks.
//   ALU results normally win the write port. A starvation counter limits how
//   many consecutive cycles the ALU can take the port while loads are queued.
//   At the limit the arbiter forces one FIFO pop and raises o_alu_stall.
//
// Configuration macro:
//   WB_BYPASS_EN - when defined, a load accepted while the FIFO is empty and
//                  no ALU result is present skips the FIFO. It is written on
//                  the next cycle.
//
// Parameters:
//   XLEN         data width
//   DEPTH        load FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT consecutive ALU wins over a non-empty FIFO before a forced pop
//
// Ports:
//   i_clk          clock, all state on posedge
//   i_rst_n        asynchronous active-low reset
//   i_alu_valid    ALU result valid
//   i_alu_rd       ALU destination register
//   i_alu_data     ALU result
//   i_ld_valid     load result valid
//   o_ld_ready     FIFO can accept a load result
//   i_ld_rd        load destination register
//   i_ld_data      load result
//   o_alu_stall    issue stage must not assert alu_valid next cycle
//   o_wen          register-file write enable (registered)
//   o_wsel         register-file write index (registered)
//   o_wdata        register-file write data (registered)
//   o_busy_mask    bit i set while any queued load targets x<i>
//   o_fifo_count   occupied FIFO entries

module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_alu_valid,
  input  logic [4:0]               i_alu_rd,
  input  logic [XLEN-1:0]          i_alu_data,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [4:0]               i_ld_rd,
  input  logic [XLEN-1:0]          i_ld_data,
  output logic                     o_alu_stall,
  output logic                     o_wen,
  output logic [4:0]               o_wsel,
  output logic [XLEN-1:0]          o_wdata,
  output logic [31:0]              o_busy_mask,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALU_PRI = 2'd1,
    S_FORCE   = 2'd2
  } state_t;

  // FIFO storage and per-entry valid flags (valid flags feed the busy mask)
  logic [4:0]      r_mem_rd   [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_starve;
  logic [SW-1:0]   w_starve_nxt;

  // Held low for the first cycle after reset so ld_ready reads 0 while in reset
  logic            r_live;

  logic            r_wen;
  logic [4:0]      r_wsel;
  logic [XLEN-1:0] r_wdata;
  logic            w_wen_nxt;
  logic [4:0]      w_wsel_nxt;
  logic [XLEN-1:0] w_wdata_nxt;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_push_fifo;
  logic            w_pop;
  logic            w_bypass;
  logic            w_force;
  logic            w_alu_win;
  logic [CW-1:0]   w_count_nxt;

  // ---------------------------------------------------------------------------
  // Handshake and arbitration decode
  // ---------------------------------------------------------------------------
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign o_ld_ready = r_live & ~w_full;
  // A full FIFO refuses the load even when a pop frees a slot this cycle
  assign w_push     = i_ld_valid & o_ld_ready;

`ifdef WB_BYPASS_EN
  assign w_bypass = w_push & w_empty & ~i_alu_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // Loads to x0 complete the handshake but are discarded here.
  // They never occupy a slot, set a busy bit or write.
  assign w_push_fifo = w_push & (i_ld_rd != 5'd0) & ~w_bypass;

  assign w_alu_win   = i_alu_valid & ~w_force;
  // In FORCE the head pops regardless of alu_valid; that ALU result is lost
  assign w_pop       = ~w_empty & (w_force | ~i_alu_valid);

  assign w_count_nxt = r_count + CW'(w_push_fifo) - CW'(w_pop);

  always_comb begin
    w_wen_nxt   = 1'b0;
    w_wsel_nxt  = r_wsel;
    w_wdata_nxt = r_wdata;
    if (w_alu_win) begin
      w_wen_nxt   = (i_alu_rd != 5'd0);
      w_wsel_nxt  = i_alu_rd;
      w_wdata_nxt = i_alu_data;
    end else if (w_pop) begin
      w_wen_nxt   = 1'b1;
      w_wsel_nxt  = r_mem_rd[r_rd_ptr];
      w_wdata_nxt = r_mem_data[r_rd_ptr];
    end else if (w_bypass) begin
      w_wen_nxt   = (i_ld_rd != 5'd0);
      w_wsel_nxt  = i_ld_rd;
      w_wdata_nxt = i_ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    case (r_state)
      S_IDLE: begin
        w_starve_nxt = '0;
        if (w_push_fifo) begin
          w_state_nxt = S_ALU_PRI;
        end
      end
      S_ALU_PRI: begin
        if (w_alu_win) begin
          w_starve_nxt = r_starve + 1'b1;
          if (r_starve == SW'(STARVE_LIMIT - 1)) begin
            w_state_nxt = S_FORCE;
          end
        end else if (w_pop) begin
          w_starve_nxt = '0;
          if (w_count_nxt == '0) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FORCE: begin
        w_starve_nxt = '0;
        w_state_nxt  = (w_count_nxt != '0) ? S_ALU_PRI : S_IDLE;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_starve_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register, so glitch-free)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_force     = (r_state == S_FORCE);
    o_alu_stall = w_force;
  end

  // ---------------------------------------------------------------------------
  // FIFO control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_count <= w_count_nxt;
      if (w_push_fifo) begin
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr] <= 1'b0;
      end
    end
  end

  // Payload storage carries no reset; the valid flags gate every use of it
  always_ff @(posedge i_clk) begin
    if (w_push_fifo) begin
      r_mem_rd[r_wr_ptr]   <= i_ld_rd;
      r_mem_data[r_wr_ptr] <= i_ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wen   <= 1'b0;
      r_wsel  <= '0;
      r_wdata <= '0;
    end else begin
      r_wen   <= w_wen_nxt;
      r_wsel  <= w_wsel_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  assign o_wen        = r_wen;
  assign o_wsel       = r_wsel;
  assign o_wdata      = r_wdata;
  assign o_fifo_count = r_count;

  // Duplicate destinations simply OR together, so a bit stays set until the
  // last entry for that register has popped
  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        o_busy_mask[r_mem_rd[i]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        alu_stall;
  logic        wen;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic [31:0] busy_mask;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_alu_valid  (alu_valid),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .i_ld_valid   (ld_valid),
    .o_ld_ready   (ld_ready),
    .i_ld_rd      (ld_rd),
    .i_ld_data    (ld_data),
    .o_alu_stall  (alu_stall),
    .o_wen        (wen),
    .o_wsel       (wsel),
    .o_wdata      (wdata),
    .o_busy_mask  (busy_mask),
    .o_fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending loads plus a starvation tally
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  bit          m_force;
  bit          m_live;
  bit          m_wen;
  int          m_starve;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdata;

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (q_rd[i]) m[q_rd[i]] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    m_force  = 0;
    m_live   = 0;
    m_wen    = 0;
    m_starve = 0;
    m_wsel   = '0;
    m_wdata  = '0;
  endtask

  task automatic model_pop();
    m_wen   = 1;
    m_wsel  = q_rd.pop_front();
    m_wdata = q_data.pop_front();
  endtask

  // Evaluate one clock edge using the inputs currently applied
  task automatic model_clock();
    int sz;
    bit push;
    bit bypass;
    sz     = q_rd.size();
    push   = ld_valid && m_live && (sz < DEPTH);
    bypass = 0;
`ifdef WB_BYPASS_EN
    bypass = push && (sz == 0) && !alu_valid;
`endif
    m_wen = 0;
    if (m_force) begin
      model_pop();
      m_force  = 0;
      m_starve = 0;
    end else if (alu_valid) begin
      m_wen = (alu_rd != 0);
      if (m_wen) begin
        m_wsel  = alu_rd;
        m_wdata = alu_data;
      end
      if (sz > 0) begin
        m_starve++;
        if (m_starve >= LIMIT) m_force = 1;
      end
    end else if (sz > 0) begin
      model_pop();
      m_starve = 0;
    end else if (bypass) begin
      m_wen = (ld_rd != 0);
      if (m_wen) begin
        m_wsel  = ld_rd;
        m_wdata = ld_data;
      end
    end
    if (push && !bypass && ld_rd != 0) begin
      q_rd.push_back(ld_rd);
      q_data.push_back(ld_data);
    end
    m_live = 1;
  endtask

  task automatic check_all(input string where);
    check({where, ".wen"}, 64'(wen), 64'(m_wen));
    if (m_wen) begin
      check({where, ".wsel"}, 64'(wsel), 64'(m_wsel));
      check({where, ".wdata"}, 64'(wdata), 64'(m_wdata));
    end
    check({where, ".count"}, 64'(fifo_count), 64'(q_rd.size()));
    check({where, ".busy"}, 64'(busy_mask), 64'(model_busy()));
    check({where, ".stall"}, 64'(alu_stall), 64'(m_force));
    check({where, ".ready"}, 64'(ld_ready), 64'(m_live && q_rd.size() < DEPTH));
  endtask

  task automatic cycle(input string where);
    model_clock();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic idle_inputs();
    alu_valid = 0;
    ld_valid  = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    check("reset.wsel", 64'(wsel), 64'd0);
    check("reset.wdata", 64'(wdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;
    #1;
    check("release.ready_low", 64'(ld_ready), 64'd0);
  endtask

  task automatic set_alu(input bit v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic set_ld(input bit v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v;
    ld_rd    = rd;
    ld_data  = d;
  endtask

  initial begin
    @(posedge clk);
    #1;
    apply_reset();

    // Reset flushes queued loads
    idle_inputs();
    cycle("t1.live");
    check("t1.ready_after_release", 64'(ld_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      set_alu(1, 5'd20, 32'h100 + i);
      set_ld(1, 5'(11 + i), 32'h200 + i);
      cycle("t1.fill");
    end
    check("t1.count_before_reset", 64'(fifo_count), 64'd3);
    apply_reset();
    check("t1.count_flushed", 64'(fifo_count), 64'd0);
    check("t1.busy_flushed", 64'(busy_mask), 64'd0);
    check("t1.wen_flushed", 64'(wen), 64'd0);
    cycle("t1.release");
    check("t1.ready_high", 64'(ld_ready), 64'd1);

    // ALU write lands one cycle later
    set_alu(1, 5'd5, 32'hDEADBEEF);
    cycle("t2.alu");
    check("t2.wen", 64'(wen), 64'd1);
    check("t2.wsel", 64'(wsel), 64'd5);
    check("t2.wdata", 64'(wdata), 64'hDEADBEEF);
    idle_inputs();
    cycle("t2.idle");

    // FIFO fills while ALU keeps the port
    for (int i = 1; i <= 4; i++) begin
      set_alu(1, 5'd21, 32'h300 + i);
      set_ld(1, 5'(i), 32'h400 + i);
      cycle("t3.fill");
    end
    check("t3.count_full", 64'(fifo_count), 64'd4);
    check("t3.ready_full", 64'(ld_ready), 64'd0);
    check("t3.busy_full", 64'(busy_mask), 64'h1E);
    set_ld(1, 5'd6, 32'h999);
    cycle("t3.fifth");
    check("t3.fifth_not_taken", 64'(fifo_count), 64'd3);
    check("t3.busy_after_pop", 64'(busy_mask), 64'h1C);
    idle_inputs();
    repeat (5) cycle("t3.drain");

    // Starvation forces a pop
    set_alu(1, 5'd10, 32'hA0);
    set_ld(1, 5'd7, 32'h77);
    cycle("t4.push");
    ld_valid = 0;
    for (int i = 0; i < 3; i++) begin
      alu_data = 32'hA1 + i;
      cycle("t4.alu");
    end
    check("t4.stall", 64'(alu_stall), 64'd1);
    check("t4.busy7_set", 64'(busy_mask[7]), 64'd1);
    cycle("t4.force");
    check("t4.force_wsel", 64'(wsel), 64'd7);
    check("t4.force_wdata", 64'(wdata), 64'h77);
    check("t4.busy7_clear", 64'(busy_mask[7]), 64'd0);
    check("t4.stall_exit", 64'(alu_stall), 64'd0);
    idle_inputs();
    cycle("t4.idle");

    // Register zero on both paths
    set_alu(1, 5'd0, 32'h1234);
    cycle("t5.alu0");
    check("t5.alu0_wen", 64'(wen), 64'd0);
    alu_valid = 0;
    set_ld(1, 5'd0, 32'h5678);
    check("t5.ld0_ready", 64'(ld_ready), 64'd1);
    cycle("t5.ld0");
    check("t5.ld0_busy", 64'(busy_mask), 64'd0);
    check("t5.ld0_wen", 64'(wen), 64'd0);
    ld_valid = 0;
    cycle("t5.ld0_after");
    check("t5.ld0_no_write", 64'(wen), 64'd0);

    // Load on an idle block: bypass or FIFO latency
    set_ld(1, 5'd9, 32'h99);
    cycle("t6.push");
    ld_valid = 0;
`ifdef WB_BYPASS_EN
    check("t6.bypass_wen", 64'(wen), 64'd1);
    check("t6.bypass_wsel", 64'(wsel), 64'd9);
    cycle("t6.after");
`else
    check("t6.fifo_wen_early", 64'(wen), 64'd0);
    cycle("t6.pop");
    check("t6.fifo_wen", 64'(wen), 64'd1);
    check("t6.fifo_wsel", 64'(wsel), 64'd9);
`endif

    // Randomized traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
      end
      if (alu_stall) alu_valid = ($urandom_range(0, 7) == 0);
      else alu_valid = ($urandom_range(0, 9) < 4);
      alu_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_data = $urandom;
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      ld_data  = $urandom;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
